// File: rtl/featuremap_pad_writer_pkg.sv
// Shared definitions for the featuremap padding writer and the featuremap
// wrappers that sit around it.
//
// Contents:
//   STATE_*         3-bit encodings of the padding FSM states
//   pad_state_e     enum built on those encodings
//   FM_WORD_WIDTH   native pixel word width (IEEE-754 single)
//   FM_ZERO_WORD    all-zero padding word
//   is_emit_state   true for every state that writes to the downstream FIFO
//
// Configuration macro (consumed by featuremap_pad_writer):
//   FEATUREMAP_PAD_WRITER_RELU_EN  clamp negative pixels to zero on output

package featuremap_pad_writer_pkg;

    localparam logic [2:0] STATE_IDLE       = 3'd0;
    localparam logic [2:0] STATE_PAD_TOP    = 3'd1;
    localparam logic [2:0] STATE_PAD_LEFT   = 3'd2;
    localparam logic [2:0] STATE_PIXEL      = 3'd3;
    localparam logic [2:0] STATE_PAD_RIGHT  = 3'd4;
    localparam logic [2:0] STATE_PAD_BOTTOM = 3'd5;

    typedef enum logic [2:0] {
        PS_IDLE       = STATE_IDLE,
        PS_PAD_TOP    = STATE_PAD_TOP,
        PS_PAD_LEFT   = STATE_PAD_LEFT,
        PS_PIXEL      = STATE_PIXEL,
        PS_PAD_RIGHT  = STATE_PAD_RIGHT,
        PS_PAD_BOTTOM = STATE_PAD_BOTTOM
    } pad_state_e;

    localparam int                     FM_WORD_WIDTH = 32;
    localparam logic [FM_WORD_WIDTH-1:0] FM_ZERO_WORD  = '0;

    function automatic logic is_emit_state(input pad_state_e s);
        return s != PS_IDLE;
    endfunction

endpackage

// File: rtl/pad_writer_buffer.sv
// Synchronous pixel FIFO that absorbs downstream stalls for the pad writer.
//
// Parameters:
//   DATA_WIDTH  word width
//   BUF_DEPTH   number of entries (power of two, at least 2)
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   push        write request; accepted when not full, or when full but
//               a pop happens in the same cycle
//   data_in     word to write
//   pop         read request; ignored when empty
//   full/empty  fill status
//   head        oldest stored word (valid when !empty)

module pad_writer_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  push_en;
    logic                  pop_en;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign head  = mem[rd_ptr_q];

    // A pop on the same cycle frees the slot, so a full buffer can still
    // take a new word. Pointers wrap naturally because depth is a power of two.
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: rtl/featuremap_pad_writer.sv
// Writes an unpadded WIDTH x WIDTH pixel stream into the next layer's input
// FIFO as a zero-padded (WIDTH+2) x (WIDTH+2) raster in row-major order.
//
// Parameters:
//   DATA_WIDTH  pixel word width
//   WIDTH       unpadded feature-map side length
//   BUF_DEPTH   internal pixel buffer depth (power of two)
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   valid_in    data_in carries a pixel this cycle (no upstream backpressure)
//   data_in     pixel word
//   fifo_full   downstream FIFO cannot take a write this cycle
//   wrreq       write strobe to downstream FIFO
//   data_out    word written when wrreq=1
//   frame_done  one-cycle pulse after the last padded word of a frame
//   overflow    sticky; a pixel arrived while the buffer was full
//
// Configuration macro:
//   FEATUREMAP_PAD_WRITER_RELU_EN  defined: pixels with the sign bit set
//   (including -0.0) are written as zero; padding is unaffected.

module featuremap_pad_writer
    import featuremap_pad_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 56,
    parameter int BUF_DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    output logic                  wrreq,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int                    CNT_W     = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0]      LAST_IDX  = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0]      PIX_LAST  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [DATA_WIDTH-1:0] ZERO_WORD = DATA_WIDTH'(FM_ZERO_WORD);

    pad_state_e            state_q, state_d;
    logic [CNT_W-1:0]      row_q, row_d;
    logic [CNT_W-1:0]      col_q, col_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overflow_q, overflow_d;

    logic                  buf_full;
    logic                  buf_empty;
    logic [DATA_WIDTH-1:0] buf_head;
    logic                  buf_pop;
    logic [DATA_WIDTH-1:0] pixel_word;

    pad_writer_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buffer (
        .clk     (clk),
        .rst     (rst),
        .push    (valid_in),
        .data_in (data_in),
        .pop     (buf_pop),
        .full    (buf_full),
        .empty   (buf_empty),
        .head    (buf_head)
    );

    // Optional ReLU sits on the pop path so both builds share the same latency.
`ifdef FEATUREMAP_PAD_WRITER_RELU_EN
    assign pixel_word = buf_head[DATA_WIDTH-1] ? ZERO_WORD : buf_head;
`else
    assign pixel_word = buf_head;
`endif

    assign buf_pop    = wrreq && (state_q == PS_PIXEL);
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

    // State register: FSM, raster counters and the two status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PS_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Next-state logic. col tracks the padded raster column, so the left pad
    // is column 0, pixels are 1..WIDTH and the right pad is WIDTH+1. Nothing
    // advances unless a write fires, which makes every stall a clean hold.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q | (valid_in && buf_full && !buf_pop);

        case (state_q)
            PS_IDLE: begin
                if (!buf_empty) begin
                    state_d = PS_PAD_TOP;
                end
            end
            PS_PAD_TOP: begin
                if (wrreq) begin
                    if (col_q == LAST_IDX) begin
                        col_d   = '0;
                        row_d   = CNT_ONE;
                        state_d = PS_PAD_LEFT;
                    end else begin
                        col_d = col_q + CNT_ONE;
                    end
                end
            end
            PS_PAD_LEFT: begin
                if (wrreq) begin
                    col_d   = CNT_ONE;
                    state_d = PS_PIXEL;
                end
            end
            PS_PIXEL: begin
                if (wrreq) begin
                    col_d = col_q + CNT_ONE;
                    if (col_q == PIX_LAST) begin
                        state_d = PS_PAD_RIGHT;
                    end
                end
            end
            PS_PAD_RIGHT: begin
                if (wrreq) begin
                    col_d = '0;
                    if (row_q == PIX_LAST) begin
                        row_d   = LAST_IDX;
                        state_d = PS_PAD_BOTTOM;
                    end else begin
                        row_d   = row_q + CNT_ONE;
                        state_d = PS_PAD_LEFT;
                    end
                end
            end
            PS_PAD_BOTTOM: begin
                if (wrreq) begin
                    if (col_q == LAST_IDX) begin
                        col_d        = '0;
                        row_d        = '0;
                        state_d      = PS_IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        col_d = col_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = PS_IDLE;
                row_d   = '0;
                col_d   = '0;
            end
        endcase
    end

    // Output logic: purely combinational so fifo_full takes effect in the
    // same cycle. A pixel write needs a word at the buffer head.
    always_comb begin
        wrreq    = 1'b0;
        data_out = ZERO_WORD;
        if (is_emit_state(state_q) && !fifo_full) begin
            wrreq = (state_q != PS_PIXEL) || !buf_empty;
        end
        if ((state_q == PS_PIXEL) && !buf_empty) begin
            data_out = pixel_word;
        end
    end

endmodule

// File: tb/tb_featuremap_pad_writer.sv
// Self-checking bench for featuremap_pad_writer (WIDTH=4, BUF_DEPTH=64).
// A negedge monitor records every fired write and frame_done pulse; each
// scenario pushes the words it expects into exp_q while driving stimulus and
// pops them against the recorded writes.

module tb_featuremap_pad_writer;

    localparam int DW    = 32;
    localparam int W     = 4;
    localparam int DEPTH = 64;
    localparam int FRAME = (W + 2) * (W + 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          fifo_full;
    logic          wrreq;
    logic [DW-1:0] data_out;
    logic          frame_done;
    logic          overflow;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          wr_cyc_q[$];
    int          done_cyc_q[$];
    int          cyc = 0;
    int          bad_writes = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] pix [W*W];

    featuremap_pad_writer #(
        .DATA_WIDTH (DW),
        .WIDTH      (W),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .wrreq      (wrreq),
        .data_out   (data_out),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every fired write and frame_done pulse mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (wrreq) begin
                obs_q.push_back(data_out);
                wr_cyc_q.push_back(cyc);
                if (fifo_full) bad_writes = bad_writes + 1;
            end
            if (frame_done) done_cyc_q.push_back(cyc);
        end
    end

    // Small integer to IEEE-754 single, exact for 1..2^23.
    function automatic logic [31:0] int_to_float(input int n);
        int          e;
        logic [31:0] m;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        m = 32'(n - (1 << e)) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic logic [31:0] relu_ref(input logic [31:0] w);
`ifdef FEATUREMAP_PAD_WRITER_RELU_EN
        return w[31] ? 32'h0 : w;
`else
        return w;
`endif
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the padded raster the current pix[] frame should produce.
    task automatic expect_frame();
        for (int r = 0; r < W + 2; r++) begin
            for (int c = 0; c < W + 2; c++) begin
                if (r >= 1 && r <= W && c >= 1 && c <= W)
                    exp_q.push_back(relu_ref(pix[(r - 1) * W + (c - 1)]));
                else
                    exp_q.push_back(32'h0);
            end
        end
    endtask

    task automatic set_ramp(input int first);
        for (int i = 0; i < W * W; i++) pix[i] = int_to_float(first + i);
    endtask

    task automatic drive_pixels();
        for (int i = 0; i < W * W; i++) begin
            valid_in = 1'b1;
            data_in  = pix[i];
            tick();
        end
        valid_in = 1'b0;
        data_in  = '0;
    endtask

    task automatic wait_writes(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (obs_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        valid_in  = 1'b0;
        data_in   = '0;
        fifo_full = 1'b0;
        #2;
        vectors++;
        if (wrreq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_wrreq: got %b expected 0", wrreq);
        end
        vectors++;
        if (data_out !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_data_out: got %h expected 00000000", data_out);
        end
        vectors++;
        if (frame_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done);
        end
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_overflow: got %b expected 0", overflow);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // One frame with pix[] preloaded, no stalls.
    task automatic test_frame(input string label);
        int base;
        int dbase;
        bit ok;
        logic [31:0] e;
        base  = obs_q.size();
        dbase = done_cyc_q.size();
        expect_frame();
        drive_pixels();
        wait_writes(base + FRAME, 400, ok);
        repeat (4) tick();
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL %s timeout: got %0d writes expected %0d", label, obs_q.size() - base, FRAME);
            exp_q.delete();
        end else begin
            for (int i = 0; i < FRAME; i++) begin
                e = exp_q.pop_front();
                vectors++;
                if (obs_q[base + i] !== e) begin
                    miscompares++;
                    $display("[TB] FAIL %s word %0d: got %h expected %h", label, i, obs_q[base + i], e);
                end
            end
        end
        if (obs_q.size() != base + FRAME) begin
            miscompares++;
            $display("[TB] FAIL %s write_count: got %0d expected %0d", label, obs_q.size() - base, FRAME);
        end
        vectors++;
        if (done_cyc_q.size() - dbase != 1) begin
            miscompares++;
            $display("[TB] FAIL %s frame_done_pulses: got %0d expected 1", label, done_cyc_q.size() - dbase);
        end
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s overflow: got %b expected 0", label, overflow);
        end
    endtask

    task automatic test_single_frame();
        set_ramp(1);
        test_frame("single_frame");
    endtask

    // Stall the downstream FIFO for 3 cycles in the middle of pixel row 2.
    task automatic test_stall();
        int base;
        bit ok;
        logic [31:0] e;
        base = obs_q.size();
        set_ramp(1);
        expect_frame();
        drive_pixels();
        wait_writes(base + 15, 200, ok);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (wrreq !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL stall_wrreq cycle %0d: got %b expected 0", i, wrreq);
            end
            tick();
        end
        fifo_full = 1'b0;
        wait_writes(base + FRAME, 400, ok);
        repeat (4) tick();
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL stall timeout: got %0d writes expected %0d", obs_q.size() - base, FRAME);
            exp_q.delete();
        end else begin
            for (int i = 0; i < FRAME; i++) begin
                e = exp_q.pop_front();
                vectors++;
                if (obs_q[base + i] !== e) begin
                    miscompares++;
                    $display("[TB] FAIL stall word %0d: got %h expected %h", i, obs_q[base + i], e);
                end
            end
        end
        vectors++;
        if (bad_writes != 0) begin
            miscompares++;
            $display("[TB] FAIL stall_write_while_full: got %0d expected 0", bad_writes);
        end
    endtask

    // 32 contiguous pixels: two frames separated by exactly one idle cycle.
    task automatic test_back_to_back();
        int base;
        int dbase;
        bit ok;
        logic [31:0] e;
        base  = obs_q.size();
        dbase = done_cyc_q.size();
        set_ramp(1);
        expect_frame();
        drive_pixels();
        set_ramp(17);
        expect_frame();
        drive_pixels();
        wait_writes(base + 2 * FRAME, 600, ok);
        repeat (4) tick();
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL b2b timeout: got %0d writes expected %0d", obs_q.size() - base, 2 * FRAME);
            exp_q.delete();
        end else begin
            for (int i = 0; i < 2 * FRAME; i++) begin
                e = exp_q.pop_front();
                vectors++;
                if (obs_q[base + i] !== e) begin
                    miscompares++;
                    $display("[TB] FAIL b2b word %0d: got %h expected %h", i, obs_q[base + i], e);
                end
            end
        end
        vectors++;
        if (done_cyc_q.size() - dbase != 2) begin
            miscompares++;
            $display("[TB] FAIL b2b frame_done_pulses: got %0d expected 2", done_cyc_q.size() - dbase);
        end else if (ok) begin
            vectors++;
            if (wr_cyc_q[base + FRAME] != done_cyc_q[dbase] + 1) begin
                miscompares++;
                $display("[TB] FAIL b2b second_frame_start: got cycle %0d expected %0d",
                         wr_cyc_q[base + FRAME], done_cyc_q[dbase] + 1);
            end
        end
    endtask

    // Fill the buffer with the FIFO blocked; one more pixel must set overflow.
    task automatic test_overflow();
        int base;
        do_reset();
        base      = obs_q.size();
        fifo_full = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            valid_in = 1'b1;
            data_in  = int_to_float(i + 1);
            tick();
        end
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL overflow_at_full: got %b expected 0", overflow);
        end
        data_in = int_to_float(DEPTH + 1);
        tick();
        valid_in = 1'b0;
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL overflow_on_drop: got %b expected 1", overflow);
        end
        repeat (5) tick();
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow);
        end
        vectors++;
        if (obs_q.size() != base) begin
            miscompares++;
            $display("[TB] FAIL overflow_no_writes: got %0d writes expected 0", obs_q.size() - base);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL overflow_cleared_by_rst: got %b expected 0", overflow);
        end
        tick();
        fifo_full = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Reset after 10 writes, then a fresh frame must come out intact.
    task automatic test_reset_mid_frame();
        int base;
        logic [31:0] e;
        base = obs_q.size();
        set_ramp(1);
        expect_frame();
        for (int i = 0; i < W * W; i++) begin
            valid_in = 1'b1;
            data_in  = pix[i];
            tick();
            if (obs_q.size() - base >= 10) break;
        end
        valid_in = 1'b0;
        rst      = 1'b1;
        #1;
        vectors++;
        if (wrreq !== 1'b0 || data_out !== 32'h0 || frame_done !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs: got wrreq=%b data_out=%h frame_done=%b overflow=%b expected 0/0/0/0",
                     wrreq, data_out, frame_done, overflow);
        end
        vectors++;
        if (obs_q.size() - base != 10) begin
            miscompares++;
            $display("[TB] FAIL midreset_write_count: got %0d expected 10", obs_q.size() - base);
            exp_q.delete();
        end else begin
            for (int i = 0; i < 10; i++) begin
                e = exp_q.pop_front();
                vectors++;
                if (obs_q[base + i] !== e) begin
                    miscompares++;
                    $display("[TB] FAIL midreset word %0d: got %h expected %h", i, obs_q[base + i], e);
                end
            end
            exp_q.delete();
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        set_ramp(101);
        test_frame("after_reset");
    endtask

    // Negative first pixel: clamped only when the ReLU build is selected.
    task automatic test_relu();
        int base;
        logic [31:0] want;
        set_ramp(1);
        pix[0] = 32'hBF800000;
        base   = obs_q.size();
        test_frame("relu_frame");
`ifdef FEATUREMAP_PAD_WRITER_RELU_EN
        want = 32'h00000000;
`else
        want = 32'hBF800000;
`endif
        vectors++;
        if (obs_q.size() < base + W + 4 || obs_q[base + W + 3] !== want) begin
            miscompares++;
            $display("[TB] FAIL relu_pixel0: got %h expected %h",
                     (obs_q.size() >= base + W + 4) ? obs_q[base + W + 3] : 32'hx, want);
        end
    endtask

    initial begin
        $display("[TB] featuremap_pad_writer bench start");
        test_reset();
        test_single_frame();
        test_stall();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_relu();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case a wait ever gets stuck.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
